lnrv_apb_master: RTL and testbench

Single-outstanding APB3 initiator. It converts a valid/ready command/response channel from the core load/store path into APB transfers toward APB peripherals such as the PLIC and timers. A programmable wait-state timeout terminates stuck transfers so the core never hangs.

---
 rtl/lnrv_apb_master.sv | 141 ++++++++++++++
 tb/tb_lnrv_apb_master.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/lnrv_apb_master.sv
// ============================================================================
// Module   : lnrv_apb_master
// Brief    : Single-outstanding APB3 initiator with wait-state timeout.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lnrv_apb_master #(
  parameter int P_ADDR_WIDTH = 8,
  parameter int P_TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [P_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]             cmd_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [31:0]             rsp_rdata,
  output logic                    rsp_err,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [P_ADDR_WIDTH-1:0] paddr,
  output logic [31:0]             pwdata,
  input  logic [31:0]             prdata,
  input  logic                    pslverr,
  input  logic                    pready
);

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_setup  = 2'd1;
  localparam logic [1:0] c_st_access = 2'd2;
  localparam logic [1:0] c_st_resp   = 2'd3;

  localparam int               c_cnt_w   = (P_TIMEOUT > 0) ? $clog2(P_TIMEOUT + 1) : 1;
  localparam bit               c_tmo_en  = (P_TIMEOUT != 0);
  localparam logic [c_cnt_w-1:0] c_cnt_max = '1;
  localparam logic [c_cnt_w-1:0] c_cnt_lim = c_cnt_w'(P_TIMEOUT - 1);

  logic [1:0]              r_state;
  logic [1:0]              w_state_nxt;
  logic [c_cnt_w-1:0]      r_cnt;
  logic [c_cnt_w-1:0]      w_cnt_nxt;
  logic                    w_accept;
  logic                    w_tmo_hit;
  logic                    w_psel_nxt;
  logic                    w_penable_nxt;
  logic                    w_cmd_ready_nxt;
  logic                    w_rsp_valid_nxt;
  logic                    w_rsp_err_nxt;
  logic [31:0]             w_rsp_rdata_nxt;
  logic                    w_pwrite_nxt;
  logic [P_ADDR_WIDTH-1:0] w_paddr_nxt;
  logic [31:0]             w_pwdata_nxt;

  assign w_accept = (r_state == c_st_idle) && cmd_valid && cmd_ready;
  // The limit is reached on the P_TIMEOUT-th ACCESS sample; pready that cycle still wins.
  assign w_tmo_hit = c_tmo_en && (r_cnt == c_cnt_lim) && !pready;

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= c_st_idle;
      r_cnt     <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      psel      <= w_psel_nxt;
      penable   <= w_penable_nxt;
      pwrite    <= w_pwrite_nxt;
      paddr     <= w_paddr_nxt;
      pwdata    <= w_pwdata_nxt;
      cmd_ready <= w_cmd_ready_nxt;
      rsp_valid <= w_rsp_valid_nxt;
      rsp_rdata <= w_rsp_rdata_nxt;
      rsp_err   <= w_rsp_err_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:   if (w_accept) w_state_nxt = c_st_setup;
      c_st_setup:  w_state_nxt = c_st_access;
      c_st_access: if (pready || w_tmo_hit) w_state_nxt = c_st_resp;
      c_st_resp:   if (rsp_ready) w_state_nxt = c_st_idle;
      default:     w_state_nxt = c_st_idle;
    endcase
  end

  // Next values for the registered outputs
  always_comb begin
    w_psel_nxt      = (w_state_nxt == c_st_setup) || (w_state_nxt == c_st_access);
    w_penable_nxt   = (w_state_nxt == c_st_access);
    w_cmd_ready_nxt = (w_state_nxt == c_st_idle);
    w_rsp_valid_nxt = (w_state_nxt == c_st_resp);
    w_rsp_err_nxt   = rsp_err;
    w_rsp_rdata_nxt = rsp_rdata;
    w_pwrite_nxt    = pwrite;
    w_paddr_nxt     = paddr;
    w_pwdata_nxt    = pwdata;
    w_cnt_nxt       = r_cnt;

    if (w_accept) begin
      w_pwrite_nxt = cmd_write;
      w_paddr_nxt  = cmd_addr;
      w_pwdata_nxt = cmd_wdata;
    end

    if (r_state == c_st_setup) begin
      w_cnt_nxt = '0;
    end else if (r_state == c_st_access) begin
      if (pready) begin
        w_rsp_err_nxt   = pslverr;
        w_rsp_rdata_nxt = (pwrite || pslverr) ? 32'd0 : prdata;
      end else begin
        if (r_cnt != c_cnt_max) w_cnt_nxt = r_cnt + 1'b1;
        if (w_tmo_hit) begin
          w_rsp_err_nxt   = 1'b1;
          w_rsp_rdata_nxt = 32'd0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lnrv_apb_master.sv
// ============================================================================
// Module   : tb_lnrv_apb_master
// Brief    : Directed self-checking bench for lnrv_apb_master (P_TIMEOUT=4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_lnrv_apb_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata, prdata;
  logic        pslverr, pready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lnrv_apb_master #(.P_ADDR_WIDTH(8), .P_TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pslverr(pslverr), .pready(pready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".psel"},      32'(psel),      32'd0);
    check({tag, ".penable"},   32'(penable),   32'd0);
    check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
  endtask

  // Present a command for one edge and check the SETUP phase that follows.
  task automatic start_cmd(input logic w, input logic [7:0] a, input logic [31:0] d);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    tick();
    cmd_valid = 1'b0; cmd_addr = 8'hFF; cmd_wdata = 32'h0; cmd_write = ~w;
    check("setup.psel",      32'(psel),      32'd1);
    check("setup.penable",   32'(penable),   32'd0);
    check("setup.cmd_ready", 32'(cmd_ready), 32'd0);
    check("setup.paddr",     32'(paddr),     32'(a));
    check("setup.pwrite",    32'(pwrite),    32'(w));
    if (w) check("setup.pwdata", pwdata, d);
  endtask

  // Enter ACCESS, hold pready low for 'waits' samples, then complete.
  task automatic run_access(input int waits, input logic [7:0] a, input logic w,
                            input logic [31:0] d, input logic [31:0] prd, input logic slv);
    pready = 1'b0;
    tick();
    check("access.penable", 32'(penable), 32'd1);
    for (int i = 0; i < waits; i++) begin
      tick();
      check("wait.penable",   32'(penable),   32'd1);
      check("wait.rsp_valid", 32'(rsp_valid), 32'd0);
      check("wait.paddr",     32'(paddr),     32'(a));
      check("wait.pwrite",    32'(pwrite),    32'(w));
      if (w) check("wait.pwdata", pwdata, d);
    end
    pready = 1'b1; prdata = prd; pslverr = slv;
    tick();
    pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
    check("done.psel",      32'(psel),      32'd0);
    check("done.penable",   32'(penable),   32'd0);
    check("done.rsp_valid", 32'(rsp_valid), 32'd1);
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("hs.rsp_valid", 32'(rsp_valid), 32'd0);
    check("hs.cmd_ready", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h0; cmd_wdata = 32'h0;
    rsp_ready = 1'b0; prdata = 32'h0; pslverr = 1'b0; pready = 1'b0;

    // Reset values
    tick(); tick();
    check_idle_outputs("rst");
    check("rst.cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst.paddr",     32'(paddr),     32'd0);
    check("rst.pwdata",    pwdata,         32'd0);
    check("rst.rsp_rdata", rsp_rdata,      32'd0);
    check("rst.rsp_err",   32'(rsp_err),   32'd0);
    reset_n = 1'b1;
    check("rel.cmd_ready", 32'(cmd_ready), 32'd0);
    tick();
    check("rel1.cmd_ready", 32'(cmd_ready), 32'd1);

    // Read, zero wait
    start_cmd(1'b0, 8'h10, 32'h0);
    run_access(0, 8'h10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);
    check("rd0.rdata", rsp_rdata, 32'hDEADBEEF);
    check("rd0.err",   32'(rsp_err), 32'd0);
    finish_rsp();

    // Write, 3 wait states (pready arrives on the timeout-limit sample and wins)
    start_cmd(1'b1, 8'h04, 32'h12345678);
    run_access(3, 8'h04, 1'b1, 32'h12345678, 32'hAAAA5555, 1'b0);
    check("wr3.rdata", rsp_rdata, 32'h0);
    check("wr3.err",   32'(rsp_err), 32'd0);
    finish_rsp();
    check("wr3.paddr_hold", 32'(paddr), 32'h04);

    // Slave error
    start_cmd(1'b0, 8'h20, 32'h0);
    run_access(0, 8'h20, 1'b0, 32'h0, 32'hFFFFFFFF, 1'b1);
    check("slv.rdata", rsp_rdata, 32'h0);
    check("slv.err",   32'(rsp_err), 32'd1);
    finish_rsp();

    // Backpressure with an ignored command pulse
    start_cmd(1'b0, 8'h40, 32'h0);
    run_access(0, 8'h40, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cmd_valid = (i == 1); cmd_addr = 8'h99; cmd_write = 1'b1;
      tick();
      check("bp.rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp.rdata",     rsp_rdata,      32'hCAFEF00D);
      check("bp.cmd_ready", 32'(cmd_ready), 32'd0);
      check("bp.psel",      32'(psel),      32'd0);
    end
    cmd_valid = 1'b0;
    finish_rsp();
    tick();
    check("bp.no_accept_psel", 32'(psel),  32'd0);
    check("bp.paddr_hold",     32'(paddr), 32'h40);

    // Timeout: pready never asserted, penable high exactly 4 cycles
    start_cmd(1'b0, 8'h30, 32'h0);
    prdata = 32'h11111111;
    tick();
    check("tmo.penable0", 32'(penable), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("tmo.penable", 32'(penable), 32'd1);
      check("tmo.rsp_valid_early", 32'(rsp_valid), 32'd0);
    end
    tick();
    check("tmo.psel",      32'(psel),      32'd0);
    check("tmo.penable_d", 32'(penable),   32'd0);
    check("tmo.rsp_valid", 32'(rsp_valid), 32'd1);
    check("tmo.err",       32'(rsp_err),   32'd1);
    check("tmo.rdata",     rsp_rdata,      32'h0);
    prdata = 32'h0;
    finish_rsp();

    // pready on the 4th ACCESS cycle completes normally
    start_cmd(1'b0, 8'h34, 32'h0);
    run_access(3, 8'h34, 1'b0, 32'h0, 32'h0BADCAFE, 1'b0);
    check("lim.err",   32'(rsp_err), 32'd0);
    check("lim.rdata", rsp_rdata,    32'h0BADCAFE);
    finish_rsp();

    // Reset while in ACCESS
    start_cmd(1'b1, 8'h50, 32'h87654321);
    tick();
    check("rsta.penable", 32'(penable), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_idle_outputs("rsta");
    check("rsta.cmd_ready", 32'(cmd_ready), 32'd0);
    check("rsta.paddr",     32'(paddr),     32'd0);
    check("rsta.pwrite",    32'(pwrite),    32'd0);
    check("rsta.pwdata",    pwdata,         32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    check("rsta.cmd_ready1", 32'(cmd_ready), 32'd1);
    check("rsta.no_rsp",     32'(rsp_valid), 32'd0);
    start_cmd(1'b0, 8'h14, 32'h0);
    run_access(0, 8'h14, 1'b0, 32'h0, 32'h5A5A5A5A, 1'b0);
    check("post.rdata", rsp_rdata, 32'h5A5A5A5A);
    check("post.err",   32'(rsp_err), 32'd0);
    finish_rsp();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
